// File: rtl/light_decode.sv
// light_decode: receive side of the 24-bit {R,G,B} light bus.
// Each valid sample is thresholded to a 3-bit colour code. A code is committed
// only after STABLE_N consecutive valid samples agree. Commits drive the
// registered colour/white outputs, a one-cycle change pulse and a wrapping
// change counter.
// Optional feature: define SEQ_CHECK_EN to build the button-sequence checker
// that drives seq_err_o. Without it, seq_err_o is tied low.
module light_decode #(
   parameter logic [7:0]  THRESH   = 8'h80,
   parameter int unsigned STABLE_N = 4,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             light_valid_i,
   input  logic [23:0]      light_i,
   output logic [2:0]       colour_o,
   output logic             colour_valid_o,
   output logic             white_o,
   output logic             change_o,
   output logic [CNT_W-1:0] change_count_o,
   output logic             seq_err_o
);

   localparam logic [7:0] StableMax = 8'(STABLE_N);
   localparam logic [2:0] CodeWhite = 3'b111;

   // Combinational decode of the raw sample
   logic [2:0] code;

   // Stability filter state
   logic [2:0] cand_q, cand_d;
   logic [7:0] cnt_q, cnt_d;
   logic       commit;
   logic       take;

   // Committed output state
   logic [2:0]       colour_q, colour_d;
   logic             colour_valid_q, colour_valid_d;
   logic             white_q, white_d;
   logic             change_q, change_d;
   logic [CNT_W-1:0] change_count_q, change_count_d;

   // Threshold each channel byte down to one bit
   always_comb begin
      code = {light_i[23:16] >= THRESH,
              light_i[15:8]  >= THRESH,
              light_i[7:0]   >= THRESH};
   end

   // Stability filter: runs only on valid samples, gaps hold the run
   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      commit = 1'b0;
      if (light_valid_i) begin
         if (code != cand_q) begin
            cand_d = code;
            cnt_d  = 8'd1;
         end else if (cnt_q != StableMax) begin
            cnt_d = cnt_q + 8'd1;
         end
         // Commit only on the sample that reaches STABLE_N; a saturated run
         // does not re-commit. With STABLE_N=1 every valid sample commits.
         if (STABLE_N == 1) begin
            commit = 1'b1;
         end else begin
            commit = (cnt_d == StableMax) && (cnt_q != StableMax);
         end
      end
   end

   // A commit is taken if it is the first one or it carries a new colour
   always_comb begin
      take = commit && (!colour_valid_q || (code != colour_q));
   end

   // Next state of the committed outputs
   always_comb begin
      colour_d       = colour_q;
      colour_valid_d = colour_valid_q;
      white_d        = white_q;
      change_d       = 1'b0;
      change_count_d = change_count_q;
      if (take) begin
         colour_d       = code;
         colour_valid_d = 1'b1;
         white_d        = (code == CodeWhite);
         change_d       = 1'b1;
         // The first commit after reset is not counted as a change
         if (colour_valid_q) begin
            change_count_d = change_count_q + CNT_W'(1);
         end
      end
   end

   // Filter and output registers, synchronous reset has priority
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cand_q         <= 3'b000;
         cnt_q          <= 8'd0;
         colour_q       <= 3'b000;
         colour_valid_q <= 1'b0;
         white_q        <= 1'b0;
         change_q       <= 1'b0;
         change_count_q <= '0;
      end else begin
         cand_q         <= cand_d;
         cnt_q          <= cnt_d;
         colour_q       <= colour_d;
         colour_valid_q <= colour_valid_d;
         white_q        <= white_d;
         change_q       <= change_d;
         change_count_q <= change_count_d;
      end
   end

   assign colour_o       = colour_q;
   assign colour_valid_o = colour_valid_q;
   assign white_o        = white_q;
   assign change_o       = change_q;
   assign change_count_o = change_count_q;

`ifdef SEQ_CHECK_EN
   // Button sequence is 001->010->011->100->101->110->001. White may be
   // entered from anywhere and left only back to the colour it interrupted.
   logic       seq_err_q, seq_err_d;
   logic [2:0] pre_white_q, pre_white_d;
   logic       seq_ok;

   function automatic logic [2:0] succ(input logic [2:0] c);
      logic [2:0] s;
      unique case (c)
         3'b001:  s = 3'b010;
         3'b010:  s = 3'b011;
         3'b011:  s = 3'b100;
         3'b100:  s = 3'b101;
         3'b101:  s = 3'b110;
         3'b110:  s = 3'b001;
         default: s = 3'b000; // 000 and 111 have no sequence successor
      endcase
      return s;
   endfunction

   // Judge each taken commit against the previous committed colour
   always_comb begin
      seq_err_d   = seq_err_q;
      pre_white_d = pre_white_q;
      seq_ok      = 1'b1;
      if (take) begin
         if (!colour_valid_q) begin
            seq_ok = (code == 3'b001) || (code == CodeWhite);
         end else if (code == CodeWhite) begin
            seq_ok = 1'b1;
         end else if (colour_q == CodeWhite) begin
            // White committed first has no prior colour: leave it to the start
            seq_ok = (pre_white_q == 3'b000) ? (code == 3'b001) : (code == pre_white_q);
         end else begin
            seq_ok = (code == succ(colour_q));
         end
         if (!seq_ok) begin
            seq_err_d = 1'b1;
         end
         // colour_q is 000 before the first commit, marking "no prior colour"
         if ((code == CodeWhite) && (colour_q != CodeWhite)) begin
            pre_white_d = colour_q;
         end
      end
   end

   // Sticky error flag and remembered pre-white colour
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         seq_err_q   <= 1'b0;
         pre_white_q <= 3'b000;
      end else begin
         seq_err_q   <= seq_err_d;
         pre_white_q <= pre_white_d;
      end
   end

   assign seq_err_o = seq_err_q;
`else
   assign seq_err_o = 1'b0;
`endif

endmodule
